hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_if.sv | 36 +++
 rtl/hazard_control_unit.sv | 118 +++++++++++
 tb/tb_hazard_control_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard signal bundle between the datapath (master) and the hazard control unit (slave).
// Control outputs are combinational in the same cycle; busy and the stall count come from registers.
interface hazard_control_unit_if #(
    parameter int REG_W = 5
);
    logic [1:0]       branch_or_jump;
    logic             jr_stall;
    logic             id_ex_memread;
    logic [REG_W-1:0] id_ex_rt;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             md_start;
    logic             md_use;
    logic             pc_write;
    logic             if_id_write;
    logic [1:0]       pc_mux_select;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             md_busy;
    logic [15:0]      stall_count;

    modport master (
        output branch_or_jump, jr_stall, id_ex_memread, id_ex_rt,
               if_id_rs, if_id_rt, if_id_uses_rt, md_start, md_use,
        input  pc_write, if_id_write, pc_mux_select, if_id_flush,
               id_ex_bubble, md_busy, stall_count
    );

    modport slave (
        input  branch_or_jump, jr_stall, id_ex_memread, id_ex_rt,
               if_id_rs, if_id_rt, if_id_uses_rt, md_start, md_use,
        output pc_write, if_id_write, pc_mux_select, if_id_flush,
               id_ex_bubble, md_busy, stall_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stalls, flushes and redirects the front end for load-use, mul/div and jump-register hazards.
// Control outputs take effect in the same cycle; a load-use hazard holds the pipe for LOAD_LAT cycles.
module hazard_control_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hif
);
    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_load_cnt;
    logic [2:0]  w_load_cnt_nxt;
    logic [7:0]  r_md_cnt;
    logic [15:0] r_stall_cnt;

    logic [REG_W-1:0] w_zero_reg;
    logic             w_load_use;
    logic             w_md_busy;
    logic             w_stall;

    assign w_zero_reg = '0;
    assign w_md_busy  = (r_md_cnt != 8'd0);

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign w_load_use = hif.id_ex_memread && (hif.id_ex_rt != w_zero_reg) &&
                        ((hif.id_ex_rt == hif.if_id_rs) ||
                         (hif.if_id_uses_rt && (hif.id_ex_rt == hif.if_id_rt)));

    assign w_stall = (r_state == LOAD_WAIT) || w_load_use ||
                     (hif.md_use && w_md_busy) ||
                     (hif.jr_stall && (hif.branch_or_jump == 2'b11));

    always_comb begin
        hif.pc_write      = 1'b1;
        hif.if_id_write   = 1'b1;
        hif.pc_mux_select = 2'b00;
        hif.if_id_flush   = 1'b0;
        hif.id_ex_bubble  = 1'b0;
        if (rst) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.if_id_flush  = 1'b1;
            hif.id_ex_bubble = 1'b1;
        end else if (w_stall) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.id_ex_bubble = 1'b1;
        end else begin
            hif.pc_mux_select = hif.branch_or_jump;
            hif.if_id_flush   = (hif.branch_or_jump != 2'b00);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_cnt_nxt = r_load_cnt;
        case (r_state)
            RUN: begin
                if (w_load_use && (LOAD_LAT > 1)) begin
                    w_state_nxt    = LOAD_WAIT;
                    w_load_cnt_nxt = 3'(LOAD_LAT - 1);
                end
            end
            LOAD_WAIT: begin
                if (r_load_cnt <= 3'd1) begin
                    w_state_nxt    = RUN;
                    w_load_cnt_nxt = 3'd0;
                end else begin
                    w_load_cnt_nxt = r_load_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_load_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_load_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_cnt <= w_load_cnt_nxt;
        end
    end

    // A new mul/div only starts on an idle unit; a start while busy is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_cnt <= 8'd0;
        end else if (hif.md_start && !w_md_busy) begin
            r_md_cnt <= 8'(MD_LAT);
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!hif.pc_write && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hif.md_busy     = w_md_busy;
    assign hif.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with LOAD_LAT=3, MD_LAT=4; expectations queued per step.
module tb_hazard_control_unit;
    localparam int REG_W = 5;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic [1:0]  mux;
        logic        flush;
        logic        bubble;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   step_no;

    hazard_control_unit_if #(.REG_W(REG_W)) hif ();

    hazard_control_unit #(
        .REG_W    (REG_W),
        .LOAD_LAT (3),
        .MD_LAT   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL step %0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be during that cycle.
    task automatic drive(input logic r, input logic [1:0] boj, input logic jr,
                         input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur, input logic ms, input logic mu,
                         input logic pcw, input logic [1:0] mux, input logic flush,
                         input logic busy, input logic [15:0] cnt);
        exp_t e;
        rst                = r;
        hif.branch_or_jump = boj;
        hif.jr_stall       = jr;
        hif.id_ex_memread  = mr;
        hif.id_ex_rt       = ert;
        hif.if_id_rs       = rs;
        hif.if_id_rt       = rt;
        hif.if_id_uses_rt  = ur;
        hif.md_start       = ms;
        hif.md_use         = mu;
        e.pcw    = pcw;
        e.ifw    = pcw;
        e.mux    = mux;
        e.flush  = flush;
        e.bubble = ~pcw;
        e.busy   = busy;
        e.cnt    = cnt;
        sb_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        #2;
        step_no++;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL step %0d scoreboard empty observed=0 expected=1", step_no);
        end else begin
            e = sb_q.pop_front();
            chk("pc_write",      {15'd0, hif.pc_write},      {15'd0, e.pcw});
            chk("if_id_write",   {15'd0, hif.if_id_write},   {15'd0, e.ifw});
            chk("pc_mux_select", {14'd0, hif.pc_mux_select}, {14'd0, e.mux});
            chk("if_id_flush",   {15'd0, hif.if_id_flush},   {15'd0, e.flush});
            chk("id_ex_bubble",  {15'd0, hif.id_ex_bubble},  {15'd0, e.bubble});
            chk("md_busy",       {15'd0, hif.md_busy},       {15'd0, e.busy});
            chk("stall_count",   hif.stall_count,            e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        rst     = 1'b1;
        hif.branch_or_jump = 2'b00;
        hif.jr_stall       = 1'b0;
        hif.id_ex_memread  = 1'b0;
        hif.id_ex_rt       = '0;
        hif.if_id_rs       = '0;
        hif.if_id_rt       = '0;
        hif.if_id_uses_rt  = 1'b0;
        hif.md_start       = 1'b0;
        hif.md_use         = 1'b0;
        @(posedge clk);
        #1;

        // Reset outputs
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 1, 0, 16'd0); compare();
        drive(1, 2'b10, 1, 1, 5, 5, 0, 0, 1, 1,   0, 2'b00, 1, 0, 16'd0); compare();
        // Plain sequencing and redirects
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd0); compare();
        drive(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b01, 1, 0, 16'd0); compare();
        drive(0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b10, 1, 0, 16'd0); compare();
        // Load-use on rs: exactly three stall cycles
        drive(0, 2'b00, 0, 1, 5, 5, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd0); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd1); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd2); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd3); compare();
        // No hazard through r0, or on rt when rt is not read
        drive(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd3); compare();
        drive(0, 2'b00, 0, 1, 7, 3, 7, 0, 0, 0,   1, 2'b00, 0, 0, 16'd3); compare();
        // Same load with rt read: hazard
        drive(0, 2'b00, 0, 1, 7, 3, 7, 1, 0, 0,   0, 2'b00, 0, 0, 16'd3); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd4); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd5); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd6); compare();
        // Branch held through a load-use stall, taken afterwards
        drive(0, 2'b01, 0, 1, 5, 5, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd6); compare();
        drive(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd7); compare();
        drive(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd8); compare();
        drive(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b01, 1, 0, 16'd9); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd9); compare();
        // Mul/div busy for four cycles; second start while busy is ignored
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1,   1, 2'b00, 0, 0, 16'd9); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2'b00, 0, 1, 16'd9); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1,   0, 2'b00, 0, 1, 16'd10); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2'b00, 0, 1, 16'd11); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2'b00, 0, 1, 16'd12); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1,   1, 2'b00, 0, 0, 16'd13); compare();
        // Busy unit without a HI/LO reader does not stall
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0,   1, 2'b00, 0, 0, 16'd13); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 1, 16'd13); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 1, 16'd13); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 1, 16'd13); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 1, 16'd13); compare();
        // Jump-register waits on its operand for two cycles
        drive(0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd13); compare();
        drive(0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd14); compare();
        drive(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b11, 1, 0, 16'd15); compare();
        drive(0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0,   1, 2'b01, 1, 0, 16'd15); compare();
        // Reset in the middle of a load wait with the mul/div unit busy
        drive(0, 2'b00, 0, 1, 5, 5, 0, 0, 0, 0,   0, 2'b00, 0, 0, 16'd15); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0,   0, 2'b00, 0, 0, 16'd16); compare();
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 1, 1, 16'd17); compare();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0, 0, 16'd0); compare();
        drive(0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0,   1, 2'b10, 1, 0, 16'd0); compare();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
